uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo_if.sv | 27 ++
 rtl/uart_tx_fifo.sv | 95 +++++++++
 tb/tb_uart_tx_fifo.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Handshake bundle between a byte producer, the TX FIFO and the UART transmitter.
// The master side writes bytes and reports transmitter status; the slave side is the FIFO.
interface uart_tx_fifo_if #(
    parameter int ADDR_W = 4
);
    logic              i_Wr_En;
    logic [7:0]        i_Wr_Data;
    logic              o_Full;
    logic              o_Empty;
    logic [ADDR_W:0]   o_Count;
    logic              o_Overflow;
    logic              o_Tx_DV;
    logic [7:0]        o_Tx_Byte;
    logic              i_Tx_Active;
    logic              i_Tx_Done;
    logic              o_Busy;

    modport master (
        output i_Wr_En, i_Wr_Data, i_Tx_Active, i_Tx_Done,
        input  o_Full, o_Empty, o_Count, o_Overflow, o_Tx_DV, o_Tx_Byte, o_Busy
    );

    modport slave (
        input  i_Wr_En, i_Wr_Data, i_Tx_Active, i_Tx_Done,
        output o_Full, o_Empty, o_Count, o_Overflow, o_Tx_DV, o_Tx_Byte, o_Busy
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO that feeds a UART transmitter: one launch strobe per byte, strictly in write order,
// with the next byte launched once the transmitter reports completion.
module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input logic          i_Clock,
    input logic          i_Reset,
    uart_tx_fifo_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT_DONE} state_t;

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    state_t            state;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              tx_dv;
    logic [7:0]        tx_byte;
    logic              full;
    logic              empty;
    logic              pop;
    logic              push;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);
    assign pop   = (state == S_IDLE) && !empty && !bus.i_Tx_Active;
    // A full FIFO still takes a write when the head leaves on the same edge.
    assign push  = bus.i_Wr_En && (!full || pop);

    always_ff @(posedge i_Clock) begin
        if (push) begin
            mem[wr_ptr] <= bus.i_Wr_Data;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            state    <= S_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            tx_dv    <= 1'b0;
            tx_byte  <= 8'h00;
        end else begin
            overflow <= bus.i_Wr_En && !push;
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (ADDR_W + 1)'(1);
                2'b01:   count <= count - (ADDR_W + 1)'(1);
                default: count <= count;
            endcase

            case (state)
                S_IDLE: begin
                    if (pop) begin
                        tx_byte <= mem[rd_ptr];
                        tx_dv   <= 1'b1;
                        state   <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    tx_dv <= 1'b0;
                    state <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (bus.i_Tx_Done) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    tx_dv <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_Full     = full;
    assign bus.o_Empty    = empty;
    assign bus.o_Count    = count;
    assign bus.o_Overflow = overflow;
    assign bus.o_Tx_DV    = tx_dv;
    assign bus.o_Tx_Byte  = tx_byte;
    assign bus.o_Busy     = (state != S_IDLE);
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a vector table for single-cycle behaviour plus
// hand-written sequences for back-to-back launches, full/overflow, pointer wrap and reset.
module tb_uart_tx_fifo;
    logic clock;
    logic rst_n;
    int   checks;
    int   errors;

    uart_tx_fifo_if #(.ADDR_W(4)) bus ();

    uart_tx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
        .i_Clock (clock),
        .i_Reset (rst_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       wr;
        logic [7:0] data;
        logic       act;
        logic       done;
        int         count;
        logic       empty;
        logic       full;
        logic       ovf;
        logic       dv;
        logic [7:0] tx_byte;
        logic       busy;
    } vec_t;

    vec_t       vecs [15];
    logic [7:0] exp_q [$];
    logic [7:0] wr_q [$];

    task automatic applyStimulus(input logic wr, input logic [7:0] data,
                                 input logic act, input logic done);
        bus.i_Wr_En     = wr;
        bus.i_Wr_Data   = data;
        bus.i_Tx_Active = act;
        bus.i_Tx_Done   = done;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic resetDut();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Transmitter model: writes queued bytes one per cycle and answers each launch with a
    // Done pulse done_delay iterations later. Done driven in iteration k is sampled at edge k,
    // so the next launch must appear in iteration k+1 (DV high two clocks after Done rose).
    task automatic runTransmitter(input int done_delay, input int first_done);
        int         done_at;
        int         done_iter;
        int         got;
        int         total;
        int         extra;
        logic       wr;
        logic [7:0] d;
        done_at   = first_done;
        done_iter = -1;
        got       = 0;
        extra     = 0;
        total     = exp_q.size();
        for (int it = 0; it < 400 + 15; it++) begin
            if (got >= total && it > done_at + 4) break;
            wr = 1'b0;
            d  = 8'h00;
            if (wr_q.size() > 0) begin
                wr = 1'b1;
                d  = wr_q.pop_front();
            end
            applyStimulus(wr, d, 1'b0, it == done_at);
            if (it == done_at) done_iter = it;
            step();
            if (bus.o_Tx_DV) begin
                if (got < total) begin
                    checkOutput("tx_byte_order", int'(bus.o_Tx_Byte), int'(exp_q.pop_front()));
                    if (done_iter >= 0) checkOutput("dv_after_done", it - done_iter, 1);
                    got++;
                end else begin
                    extra++;
                end
                done_at = it + done_delay;
            end
        end
        checkOutput("launch_count", got, total);
        checkOutput("extra_launches", extra, 0);
        checkOutput("drained_empty", int'(bus.o_Empty), 1);
        checkOutput("drained_idle", int'(bus.o_Busy), 0);
    endtask

    initial begin
        int dv_seen;
        checks = 0;
        errors = 0;

        vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1};
        vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1};
        vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0};
        vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0};
        vecs[5]  = '{1'b1, 8'h3C, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0};
        vecs[6]  = '{1'b1, 8'h5A, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b1};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b1};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b1};
        vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0};
        vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b1};
        vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b1};
        vecs[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0};

        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b0;
        step();
        checkOutput("reset_count", int'(bus.o_Count), 0);
        checkOutput("reset_empty", int'(bus.o_Empty), 1);
        checkOutput("reset_full", int'(bus.o_Full), 0);
        checkOutput("reset_dv", int'(bus.o_Tx_DV), 0);
        checkOutput("reset_byte", int'(bus.o_Tx_Byte), 0);
        checkOutput("reset_ovf", int'(bus.o_Overflow), 0);
        checkOutput("reset_busy", int'(bus.o_Busy), 0);
        step();
        rst_n = 1'b1;
        step();
        checkOutput("no_launch_after_release", int'(bus.o_Tx_DV), 0);

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].wr, vecs[i].data, vecs[i].act, vecs[i].done);
            step();
            checkOutput($sformatf("v%0d_count", i), int'(bus.o_Count), vecs[i].count);
            checkOutput($sformatf("v%0d_empty", i), int'(bus.o_Empty), int'(vecs[i].empty));
            checkOutput($sformatf("v%0d_full", i), int'(bus.o_Full), int'(vecs[i].full));
            checkOutput($sformatf("v%0d_ovf", i), int'(bus.o_Overflow), int'(vecs[i].ovf));
            checkOutput($sformatf("v%0d_dv", i), int'(bus.o_Tx_DV), int'(vecs[i].dv));
            checkOutput($sformatf("v%0d_byte", i), int'(bus.o_Tx_Byte), int'(vecs[i].tx_byte));
            checkOutput($sformatf("v%0d_busy", i), int'(bus.o_Busy), int'(vecs[i].busy));
        end

        resetDut();
        wr_q  = '{8'h01, 8'h02, 8'h03};
        exp_q = '{8'h01, 8'h02, 8'h03};
        runTransmitter(10, -1);

        resetDut();
        dv_seen = 0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 8'(8'h10 + i), 1'b1, 1'b0);
            step();
            if (bus.o_Tx_DV) dv_seen++;
            checkOutput($sformatf("fill_ovf_%0d", i), int'(bus.o_Overflow), 0);
        end
        checkOutput("fill_full", int'(bus.o_Full), 1);
        checkOutput("fill_count", int'(bus.o_Count), 16);
        applyStimulus(1'b1, 8'hFF, 1'b1, 1'b0);
        step();
        if (bus.o_Tx_DV) dv_seen++;
        checkOutput("overflow_pulse", int'(bus.o_Overflow), 1);
        checkOutput("overflow_count", int'(bus.o_Count), 16);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        step();
        if (bus.o_Tx_DV) dv_seen++;
        checkOutput("overflow_one_cycle", int'(bus.o_Overflow), 0);
        checkOutput("held_count", int'(bus.o_Count), 16);
        checkOutput("no_dv_while_active", dv_seen, 0);

        // Push into a full FIFO on the same edge the head is launched; wr_ptr wraps to slot 0.
        applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0);
        step();
        checkOutput("full_pop_count", int'(bus.o_Count), 16);
        checkOutput("full_pop_ovf", int'(bus.o_Overflow), 0);
        checkOutput("full_pop_dv", int'(bus.o_Tx_DV), 1);
        checkOutput("full_pop_byte", int'(bus.o_Tx_Byte), 8'h10);
        wr_q.delete();
        exp_q.delete();
        for (int i = 1; i < 16; i++) exp_q.push_back(8'(8'h10 + i));
        exp_q.push_back(8'hEE);
        runTransmitter(3, 2);

        resetDut();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
            step();
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("pre_reset_count", int'(bus.o_Count), 5);
        checkOutput("pre_reset_busy", int'(bus.o_Busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_count", int'(bus.o_Count), 0);
        checkOutput("async_reset_empty", int'(bus.o_Empty), 1);
        checkOutput("async_reset_dv", int'(bus.o_Tx_DV), 0);
        checkOutput("async_reset_busy", int'(bus.o_Busy), 0);
        step();
        step();
        rst_n = 1'b1;
        dv_seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.o_Tx_DV) dv_seen++;
        end
        checkOutput("no_dv_after_reset", dv_seen, 0);
        checkOutput("empty_after_reset", int'(bus.o_Empty), 1);
        applyStimulus(1'b1, 8'h77, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        step();
        checkOutput("new_write_dv", int'(bus.o_Tx_DV), 1);
        checkOutput("new_write_byte", int'(bus.o_Tx_Byte), 8'h77);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
